// File: rtl/alu16_pkg.sv
// Shared constants and types for the registered 16-bit ALU.
// Optional ALU16_EXT_FLAGS_EN adds carry-out and overflow outputs.
package alu16_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_NOT   = 3'b101,
    OP_NEG   = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

  localparam logic [ALU_WIDTH-1:0] W_RST   = '0;
  localparam logic                 ZER_RST = 1'b1;
  localparam logic                 NEG_RST = 1'b0;
  localparam logic                 EXT_RST = 1'b0;

endpackage

// File: rtl/alu16_addsub.sv
// Combinational add/subtract unit shared by ADD, SUB and NEG.
// cout/ovf ports exist only with ALU16_EXT_FLAGS_EN.
module alu16_addsub
  import alu16_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
`ifdef ALU16_EXT_FLAGS_EN
  output logic             cout,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] s
);

  logic [WIDTH-1:0] bx;

  assign bx = sub ? ~b : b;

`ifdef ALU16_EXT_FLAGS_EN
  logic [WIDTH:0] t;

  assign t    = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
  assign s    = t[WIDTH-1:0];
  assign cout = t[WIDTH];
  assign ovf  = (a[WIDTH-1] == bx[WIDTH-1])
              & (s[WIDTH-1] != a[WIDTH-1]);
`else
  assign s = a + bx + {{(WIDTH-1){1'b0}}, cin};
`endif

endmodule

// File: rtl/alu16_reg.sv
// Registered 8-op ALU with zero/negative flags, one-cycle latency.
// ALU16_EXT_FLAGS_EN adds registered cout and ovf outputs.
module alu16_reg
  import alu16_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opc,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             inc,
  output logic [WIDTH-1:0] w,
  output logic             zer,
`ifdef ALU16_EXT_FLAGS_EN
  output logic             cout,
  output logic             ovf,
`endif
  output logic             neg
);

  op_e              op;
  logic [WIDTH-1:0] as_a;
  logic [WIDTH-1:0] as_b;
  logic             as_sub;
  logic             as_cin;
  logic [WIDTH-1:0] as_s;
  logic [WIDTH-1:0] r;

  assign op = op_e'(opc);

  // NEG is computed as 0 - ina on the shared adder
  always_comb begin
    as_a   = ina;
    as_b   = inb;
    as_sub = 1'b0;
    as_cin = inc;
    unique case (1'b1)
      (op == OP_SUB): begin
        as_sub = 1'b1;
        as_cin = ~inc;
      end
      (op == OP_NEG): begin
        as_a   = '0;
        as_b   = ina;
        as_sub = 1'b1;
        as_cin = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ALU16_EXT_FLAGS_EN
  logic as_cout;
  logic as_ovf;
  logic is_addsub;
  logic is_arith;

  alu16_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (as_a),
    .b    (as_b),
    .sub  (as_sub),
    .cin  (as_cin),
    .cout (as_cout),
    .ovf  (as_ovf),
    .s    (as_s)
  );

  assign is_addsub = (op == OP_ADD) | (op == OP_SUB);
  assign is_arith  = is_addsub | (op == OP_NEG);

  always_ff @(posedge clk) begin
    if (rst) begin
      cout <= EXT_RST;
      ovf  <= EXT_RST;
    end else begin
      cout <= is_addsub & as_cout;
      ovf  <= is_arith & as_ovf;
    end
  end
`else
  alu16_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .cin (as_cin),
    .s   (as_s)
  );
`endif

  always_comb begin
    r = '0;
    unique case (1'b1)
      (op == OP_ADD),
      (op == OP_SUB),
      (op == OP_NEG):   r = as_s;
      (op == OP_AND):   r = ina & inb;
      (op == OP_OR):    r = ina | inb;
      (op == OP_XOR):   r = ina ^ inb;
      (op == OP_NOT):   r = ~ina;
      (op == OP_PASSB): r = inb;
      default:          r = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w   <= W_RST;
      zer <= ZER_RST;
      neg <= NEG_RST;
    end else begin
      w   <= r;
      zer <= (r == '0);
      neg <= r[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_alu16_reg.sv
// Scoreboard bench for alu16_reg: directed vectors plus an opcode sweep.
// Checks cout/ovf as well when ALU16_EXT_FLAGS_EN is defined.
module tb_alu16_reg;

  typedef struct {
    logic [15:0] w;
    logic        zer;
    logic        neg;
    logic        cout;
    logic        ovf;
    int          tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  opc;
  logic [15:0] ina;
  logic [15:0] inb;
  logic        inc;
  logic [15:0] w;
  logic        zer;
  logic        neg;
  logic        cout;
  logic        ovf;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_tag  = 0;

  always #5 clk = ~clk;

`ifdef ALU16_EXT_FLAGS_EN
  alu16_reg dut (
    .clk  (clk),
    .rst  (rst),
    .opc  (opc),
    .ina  (ina),
    .inb  (inb),
    .inc  (inc),
    .w    (w),
    .zer  (zer),
    .cout (cout),
    .ovf  (ovf),
    .neg  (neg)
  );
`else
  alu16_reg dut (
    .clk (clk),
    .rst (rst),
    .opc (opc),
    .ina (ina),
    .inb (inb),
    .inc (inc),
    .w   (w),
    .zer (zer),
    .neg (neg)
  );
  assign cout = 1'b0;
  assign ovf  = 1'b0;
`endif

  // Golden model built on 17-bit integer arithmetic
  function automatic exp_t model(input logic [2:0] o,
                                 input logic [15:0] a,
                                 input logic [15:0] b,
                                 input logic c);
    exp_t e;
    logic [16:0] t;
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    e.tag  = 0;
    case (o)
      3'd0: begin
        t = {1'b0, a} + {1'b0, b} + {16'd0, c};
        e.w = t[15:0];
        e.cout = t[16];
        e.ovf = (a[15] == b[15]) && (e.w[15] != a[15]);
      end
      3'd1: begin
        e.w = a - b - {15'd0, c};
        e.cout = ({1'b0, a} >= ({1'b0, b} + {16'd0, c}));
        e.ovf = (a[15] != b[15]) && (e.w[15] != a[15]);
      end
      3'd2: e.w = a & b;
      3'd3: e.w = a | b;
      3'd4: e.w = a ^ b;
      3'd5: e.w = ~a;
      3'd6: begin
        e.w = 16'd0 - a;
        e.ovf = (a == 16'h8000);
      end
      default: e.w = b;
    endcase
    e.zer = (e.w == 16'd0);
    e.neg = e.w[15];
    return e;
  endfunction

  task automatic issue(input logic r,
                       input logic [2:0] o,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic c,
                       input logic [15:0] ew,
                       input logic ez,
                       input logic en);
    exp_t e;
    @(negedge clk);
    rst = r;
    opc = o;
    ina = a;
    inb = b;
    inc = c;
    if (r) begin
      e.cout = 1'b0;
      e.ovf  = 1'b0;
    end else begin
      e = model(o, a, b, c);
    end
    e.w   = ew;
    e.zer = ez;
    e.neg = en;
    e.tag = n_tag;
    n_tag++;
    q.push_back(e);
  endtask

  task automatic issue_m(input logic [2:0] o,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         input logic c);
    exp_t m;
    m = model(o, a, b, c);
    issue(1'b0, o, a, b, c, m.w, m.zer, m.neg);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        #1;
        e = q.pop_front();
        n_chk++;
        if (w !== e.w || zer !== e.zer || neg !== e.neg) begin
          n_fail++;
          $display("FAIL vec%0d w/zer/neg got %h/%b/%b want %h/%b/%b",
                   e.tag, w, zer, neg, e.w, e.zer, e.neg);
        end
`ifdef ALU16_EXT_FLAGS_EN
        n_chk++;
        if (cout !== e.cout || ovf !== e.ovf) begin
          n_fail++;
          $display("FAIL vec%0d cout/ovf got %b/%b want %b/%b",
                   e.tag, cout, ovf, e.cout, e.ovf);
        end
`endif
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    opc = 3'd0;
    ina = 16'd0;
    inb = 16'd0;
    inc = 1'b0;

    issue(1'b1, 3'd0, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b1, 1'b0);
    issue(1'b1, 3'd0, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b1, 1'b0);
    issue(1'b0, 3'd0, 16'h1234, 16'h5678, 1'b0, 16'h68AC, 1'b0, 1'b0);

    issue(1'b0, 3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    issue(1'b0, 3'd0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0);
    issue(1'b0, 3'd1, 16'h0003, 16'h0005, 1'b1, 16'hFFFD, 1'b0, 1'b1);
    issue(1'b0, 3'd1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    issue(1'b0, 3'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

    issue(1'b0, 3'd2, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b1);
    issue(1'b0, 3'd3, 16'hF0F0, 16'hFF00, 1'b1, 16'hFFF0, 1'b0, 1'b1);
    issue(1'b0, 3'd4, 16'hF0F0, 16'hFF00, 1'b1, 16'h0FF0, 1'b0, 1'b0);
    issue(1'b0, 3'd5, 16'hF0F0, 16'hFF00, 1'b1, 16'h0F0F, 1'b0, 1'b0);
    issue(1'b0, 3'd7, 16'hF0F0, 16'hFF00, 1'b1, 16'hFF00, 1'b0, 1'b1);
    issue(1'b0, 3'd2, 16'h00FF, 16'hFF00, 1'b0, 16'h0000, 1'b1, 1'b0);

    issue(1'b0, 3'd6, 16'h8000, 16'h1111, 1'b1, 16'h8000, 1'b0, 1'b1);
    issue(1'b0, 3'd6, 16'h0000, 16'h1111, 1'b1, 16'h0000, 1'b1, 1'b0);
    issue(1'b0, 3'd6, 16'h0001, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1);

    issue(1'b1, 3'd5, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      issue_m(3'(i % 8), 16'($urandom), 16'($urandom), 1'($urandom));
    end

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
